sol1_bus_ctrl: RTL and testbench

//  External bus interface for the Sol-1 CPU, sitting between the cpu_top core (MAR/MDR, ctrl_rd/ctrl_wr)
//  and the board pins. Runs one memory or I/O cycle per request with programmable setup, strobe and

---
 rtl/sol1_bus_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sol1_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sol1_bus_ctrl.sv
// Sol-1 external bus sequencer: one memory/I/O cycle per core request with
// setup/strobe/wait timing, bus timeout, and a DMA request/acknowledge handshake.
module sol1_bus_ctrl #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_io,
  input  logic [5:0]  req_page,
  input  logic [15:0] req_mar,
  input  logic [7:0]  req_wdata,
  input  logic        pad_wait,
  input  logic        dma_req,
  input  logic [7:0]  data_in,
  output logic [21:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        rd,
  output logic        wr,
  output logic        mem_io,
  output logic        dma_ack,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        bus_err
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DMA, REL} state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX    = 8'(WAIT_TIMEOUT);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx, wcnt, wcnt_nx;
  logic        is_rd, is_rd_nx;
  logic        pw_meta, pw_s, dr_meta, dr_s;
  logic [21:0] addr_nx;
  logic [7:0]  data_out_nx, rd_data_nx;
  logic        data_oe_nx, rd_nx, wr_nx, mem_io_nx, dma_ack_nx, busy_nx, done_nx, bus_err_nx;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pw_meta <= 1'b0; pw_s <= 1'b0;
      dr_meta <= 1'b0; dr_s <= 1'b0;
    end else begin
      pw_meta <= pad_wait; pw_s <= pw_meta;
      dr_meta <= dma_req;  dr_s <= dr_meta;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      cnt      <= '0;
      wcnt     <= '0;
      is_rd    <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      mem_io   <= 1'b0;
      dma_ack  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wcnt     <= wcnt_nx;
      is_rd    <= is_rd_nx;
      addr     <= addr_nx;
      data_out <= data_out_nx;
      data_oe  <= data_oe_nx;
      rd       <= rd_nx;
      wr       <= wr_nx;
      mem_io   <= mem_io_nx;
      dma_ack  <= dma_ack_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      rd_data  <= rd_data_nx;
      bus_err  <= bus_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    wcnt_nx     = wcnt;
    is_rd_nx    = is_rd;
    addr_nx     = addr;
    data_out_nx = data_out;
    data_oe_nx  = data_oe;
    rd_nx       = rd;
    wr_nx       = wr;
    mem_io_nx   = mem_io;
    dma_ack_nx  = dma_ack;
    busy_nx     = busy;
    done_nx     = 1'b0;
    bus_err_nx  = 1'b0;
    rd_data_nx  = rd_data;
    unique case (state)
      IDLE: begin
        // CPU request takes priority over a DMA request seen on the same edge
        if (req_rd ^ req_wr) begin
          state_nx    = SETUP;
          addr_nx     = {req_page, req_mar};
          mem_io_nx   = req_io;
          data_out_nx = req_wdata;
          data_oe_nx  = req_wr;
          is_rd_nx    = req_rd;
          busy_nx     = 1'b1;
          cnt_nx      = '0;
        end else if (req_rd & req_wr) begin
          state_nx   = HOLD;
          busy_nx    = 1'b1;
          done_nx    = 1'b1;
          bus_err_nx = 1'b1;
        end else if (dr_s) begin
          state_nx   = DMA;
          dma_ack_nx = 1'b1;
          addr_nx    = '0;
          data_oe_nx = 1'b0;
          busy_nx    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = STROBE;
          cnt_nx   = '0;
          wcnt_nx  = '0;
          rd_nx    = is_rd;
          wr_nx    = ~is_rd;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      STROBE: begin
        // wait states only count once the minimum strobe width has elapsed
        if (cnt != STROBE_LAST) begin
          cnt_nx = cnt + 8'd1;
        end else if (pw_s && wcnt != WAIT_MAX) begin
          wcnt_nx = wcnt + 8'd1;
        end else begin
          state_nx   = HOLD;
          rd_nx      = 1'b0;
          wr_nx      = 1'b0;
          done_nx    = 1'b1;
          bus_err_nx = pw_s;
          if (is_rd && !pw_s) rd_data_nx = data_in;
        end
      end
      HOLD: begin
        state_nx   = IDLE;
        busy_nx    = 1'b0;
        data_oe_nx = 1'b0;
      end
      DMA: begin
        if (!dr_s) begin
          state_nx   = REL;
          dma_ack_nx = 1'b0;
        end
      end
      REL: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sol1_bus_ctrl.sv
// Scenario bench for sol1_bus_ctrl: expected results are queued when a request
// is issued and popped/compared when the cycle reports done.
module tb_sol1_bus_ctrl;
  localparam int SETUP_CYCLES  = 1;
  localparam int STROBE_CYCLES = 2;
  localparam int WAIT_TIMEOUT  = 255;
  localparam int BASE_LAT      = SETUP_CYCLES + STROBE_CYCLES + 1;

  logic        clk = 1'b0, arst;
  logic        req_rd, req_wr, req_io, pad_wait, dma_req;
  logic [5:0]  req_page;
  logic [15:0] req_mar;
  logic [7:0]  req_wdata, data_in;
  logic [21:0] addr;
  logic [7:0]  data_out, rd_data;
  logic        data_oe, rd, wr, mem_io, dma_ack, busy, done, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         strobes;
  } exp_t;
  exp_t sb[$];

  sol1_bus_ctrl #(.SETUP_CYCLES(SETUP_CYCLES), .STROBE_CYCLES(STROBE_CYCLES),
                  .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .arst(arst), .req_rd(req_rd), .req_wr(req_wr), .req_io(req_io),
    .req_page(req_page), .req_mar(req_mar), .req_wdata(req_wdata),
    .pad_wait(pad_wait), .dma_req(dma_req), .data_in(data_in),
    .addr(addr), .data_out(data_out), .data_oe(data_oe), .rd(rd), .wr(wr),
    .mem_io(mem_io), .dma_ack(dma_ack), .busy(busy), .done(done),
    .rd_data(rd_data), .bus_err(bus_err));

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; the next posedge is the accept edge.
  task automatic run_req(input logic rdq, input logic wrq, input logic io,
                         input logic [5:0] pg, input logic [15:0] mar,
                         input logic [7:0] wd, input logic [7:0] din,
                         input int pw_on, input int pw_off,
                         output int lat, output int scnt, output logic [21:0] a,
                         output logic mio, output logic [7:0] dout,
                         output logic oe_ok, output logic bad_strobe,
                         output logic err, output logic [7:0] rdat, output logic tmo);
    req_rd = rdq; req_wr = wrq; req_io = io; req_page = pg; req_mar = mar;
    req_wdata = wd; data_in = din;
    if (pw_on == 0) pad_wait = 1'b1;
    lat = 0; scnt = 0; a = '0; mio = 1'b0; dout = '0; oe_ok = 1'b1;
    bad_strobe = 1'b0; err = 1'b0; rdat = '0; tmo = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      lat++;
      if (lat == pw_on)  pad_wait = 1'b1;
      if (lat == pw_off) pad_wait = 1'b0;
      if (rd || wr) begin
        if (scnt == 0) begin a = addr; mio = mem_io; dout = data_out; end
        scnt++;
        if (rd !== rdq || wr !== wrq) bad_strobe = 1'b1;
      end
      if (data_oe !== (wrq & ~rdq)) oe_ok = 1'b0;
      if (done) begin
        err = bus_err; rdat = rd_data; tmo = 1'b0;
        break;
      end
    end
    req_rd = 1'b0; req_wr = 1'b0; pad_wait = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({addr, data_out, rd_data} !== 38'd0) begin
      errors++; $display("FAIL reset_buses got %h/%h/%h want 0", addr, data_out, rd_data);
    end
    checks++;
    if ({data_oe, rd, wr, mem_io, dma_ack, busy, done, bus_err} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {data_oe, rd, wr, mem_io, dma_ack, busy, done, bus_err});
    end
  endtask

  task automatic test_read();
    int lat, scnt; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    exp_t e;
    sb.push_back('{rdata: 8'hA5, err: 1'b0, lat: BASE_LAT, strobes: STROBE_CYCLES});
    run_req(1, 0, 0, 6'h05, 16'h1234, 8'h00, 8'hA5, -1, -1,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL read_timeout no done"); end
    checks++; if (a !== 22'h051234) begin errors++; $display("FAIL read_addr got %h want 051234", a); end
    checks++; if (mio !== 1'b0) begin errors++; $display("FAIL read_memio got %b want 0", mio); end
    checks++; if (scnt != e.strobes || bad) begin errors++; $display("FAIL read_strobe got %0d bad=%b want %0d", scnt, bad, e.strobes); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL read_latency got %0d want %0d", lat, e.lat); end
    checks++; if (rdat !== e.rdata || err !== e.err) begin errors++; $display("FAIL read_data got %h err=%b want %h err=%b", rdat, err, e.rdata, e.err); end
    checks++; if (!oe) begin errors++; $display("FAIL read_oe got data_oe high want 0"); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after got %b want 0", busy); end
  endtask

  task automatic test_write_io();
    int lat, scnt; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    exp_t e;
    sb.push_back('{rdata: 8'hA5, err: 1'b0, lat: BASE_LAT, strobes: STROBE_CYCLES});
    run_req(0, 1, 1, 6'h2A, 16'hBEEF, 8'h3C, 8'h77, -1, -1,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL wr_timeout no done"); end
    checks++; if (a !== 22'h2ABEEF || mio !== 1'b1) begin errors++; $display("FAIL wr_addr got %h mio=%b want 2abeef mio=1", a, mio); end
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL wr_data got %h want 3c", dout); end
    checks++; if (!oe) begin errors++; $display("FAIL wr_oe got data_oe low during cycle want 1"); end
    checks++; if (scnt != e.strobes || bad) begin errors++; $display("FAIL wr_strobe got %0d bad=%b want %0d", scnt, bad, e.strobes); end
    checks++; if (lat != e.lat || err !== e.err) begin errors++; $display("FAIL wr_latency got %0d err=%b want %0d", lat, err, e.lat); end
    checks++; if (rdat !== e.rdata) begin errors++; $display("FAIL wr_rdata_kept got %h want %h", rdat, e.rdata); end
    @(negedge clk);
    checks++; if (data_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_release got oe=%b busy=%b want 0 0", data_oe, busy); end
  endtask

  task automatic test_wait();
    int lat, scnt; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    exp_t e;
    // pad_wait seen for 5 edges from the end of the minimum strobe onwards
    sb.push_back('{rdata: 8'h5A, err: 1'b0, lat: BASE_LAT + 5, strobes: STROBE_CYCLES + 5});
    run_req(1, 0, 0, 6'h01, 16'h0010, 8'h00, 8'h5A, 1, 6,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL wait_timeout no done"); end
    checks++; if (scnt != e.strobes) begin errors++; $display("FAIL wait_strobe got %0d want %0d", scnt, e.strobes); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL wait_latency got %0d want %0d", lat, e.lat); end
    checks++; if (err !== e.err || rdat !== e.rdata) begin errors++; $display("FAIL wait_result got %h err=%b want %h err=%b", rdat, err, e.rdata, e.err); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, scnt; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    exp_t e;
    sb.push_back('{rdata: 8'h5A, err: 1'b1, lat: BASE_LAT + WAIT_TIMEOUT,
                   strobes: STROBE_CYCLES + WAIT_TIMEOUT});
    run_req(0, 1, 0, 6'h00, 16'h0200, 8'h99, 8'h00, 0, 100000,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL tmo_no_done"); end
    checks++; if (scnt != e.strobes) begin errors++; $display("FAIL tmo_strobe got %0d want %0d", scnt, e.strobes); end
    checks++; if (lat != e.lat || err !== e.err) begin errors++; $display("FAIL tmo_done got lat=%0d err=%b want %0d 1", lat, err, e.lat); end
    checks++; if (rdat !== e.rdata) begin errors++; $display("FAIL tmo_rdata got %h want %h", rdat, e.rdata); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy=%b wr=%b want 0 0", busy, wr); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal();
    int lat, scnt; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    exp_t e;
    sb.push_back('{rdata: 8'h5A, err: 1'b1, lat: 1, strobes: 0});
    run_req(1, 1, 0, 6'h3F, 16'hFFFF, 8'hEE, 8'h11, -1, -1,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL ill_no_done"); end
    checks++; if (lat != e.lat || err !== e.err || scnt != e.strobes) begin errors++; $display("FAIL ill_result got lat=%0d err=%b strobes=%0d want %0d 1 0", lat, err, scnt, e.lat); end
    checks++; if (rdat !== e.rdata) begin errors++; $display("FAIL ill_rdata got %h want %h", rdat, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_dma();
    int lat, scnt, n; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    logic seen;
    exp_t e;
    dma_req = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back('{rdata: 8'hC3, err: 1'b0, lat: BASE_LAT, strobes: STROBE_CYCLES});
    run_req(1, 0, 0, 6'h07, 16'h4242, 8'h00, 8'hC3, -1, -1,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat || rdat !== e.rdata) begin errors++; $display("FAIL dma_cpu_first got lat=%0d data=%h want %0d %h", lat, rdat, e.lat, e.rdata); end
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_early got %b want 0", dma_ack); end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); seen = dma_ack; end
    checks++; if (!seen) begin errors++; $display("FAIL dma_grant got dma_ack=0 want 1"); end
    checks++; if (busy !== 1'b1 || addr !== 22'd0 || rd !== 1'b0 || data_oe !== 1'b0) begin errors++; $display("FAIL dma_bus got busy=%b addr=%h rd=%b oe=%b want 1 0 0 0", busy, addr, rd, data_oe); end
    req_rd = 1'b1;
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (rd || done) bad = 1'b1; end
    req_rd = 1'b0;
    checks++; if (bad) begin errors++; $display("FAIL dma_holdoff got core cycle during DMA want none"); end
    dma_req = 1'b0;
    n = 0; seen = 1'b1;
    for (int i = 0; i < 6 && seen; i++) begin @(negedge clk); n++; seen = dma_ack; end
    checks++; if (seen || n < 2 || n > 3) begin errors++; $display("FAIL dma_release got %0d cycles ack=%b want 2..3", n, seen); end
    repeat (2) @(negedge clk);
    sb.push_back('{rdata: 8'h81, err: 1'b0, lat: BASE_LAT, strobes: STROBE_CYCLES});
    run_req(1, 0, 0, 6'h00, 16'h0081, 8'h00, 8'h81, -1, -1,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat || rdat !== e.rdata || a !== 22'h000081) begin errors++; $display("FAIL dma_next_req got lat=%0d data=%h addr=%h want %0d %h 000081", lat, rdat, a, e.lat, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_arst();
    int lat, scnt; logic [21:0] a; logic mio, oe, bad, err, tmo; logic [7:0] dout, rdat;
    logic got_done;
    exp_t e;
    req_rd = 1'b1; req_wr = 1'b0; req_io = 1'b0; req_page = 6'h02; req_mar = 16'h0303;
    data_in = 8'h44;
    repeat (2) @(negedge clk);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL arst_pre got rd=%b want 1", rd); end
    arst = 1'b1;
    #1;
    checks++; if (rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_drop got rd=%b busy=%b want 0 0", rd, busy); end
    req_rd = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    got_done = 1'b0;
    repeat (6) begin @(negedge clk); if (done) got_done = 1'b1; end
    checks++; if (got_done) begin errors++; $display("FAIL arst_no_done got done=1 want 0"); end
    sb.push_back('{rdata: 8'h6D, err: 1'b0, lat: BASE_LAT, strobes: STROBE_CYCLES});
    run_req(1, 0, 0, 6'h02, 16'h0303, 8'h00, 8'h6D, -1, -1,
            lat, scnt, a, mio, dout, oe, bad, err, rdat, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat || rdat !== e.rdata || err !== e.err) begin errors++; $display("FAIL arst_fresh got lat=%0d data=%h err=%b want %0d %h 0", lat, rdat, err, e.lat, e.rdata); end
  endtask

  initial begin
    arst = 1'b1;
    req_rd = 1'b0; req_wr = 1'b0; req_io = 1'b0; req_page = '0; req_mar = '0;
    req_wdata = '0; pad_wait = 1'b0; dma_req = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    arst = 1'b0;
    repeat (2) @(negedge clk);
    test_read();
    test_write_io();
    test_wait();
    test_timeout();
    test_illegal();
    test_dma();
    test_arst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
